// File: rtl/bus_traffic_seq.sv
// rtl/bus_traffic_seq.sv - NUM_CH-channel write-write-read bus traffic generator with read-back self-check; optional watchdog macro BUS_TRAFFIC_SEQ_TIMEOUT_EN
module bus_traffic_seq #(
  parameter int ADDR_WIDTH           = 16,
  parameter int DATA_WIDTH           = 8,
  parameter int SLAVE_MEM_ADDR_WIDTH = 12,
  parameter int NUM_CH               = 2,
  parameter int ITER                 = 10,
  parameter int START_PULSE          = 2,
  parameter int GAP_CYCLES           = 2,
  parameter int TIMEOUT_CYCLES       = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         go,
  input  logic [NUM_CH-1:0]            ch_ready,
  input  logic [NUM_CH-1:0]            ch_rvalid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_rdata,
  output logic [NUM_CH-1:0]            ch_start,
  output logic [NUM_CH-1:0]            ch_mode,
  output logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  output logic [NUM_CH*DATA_WIDTH-1:0] ch_wdata,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [7:0]                   err_count,
  output logic [7:0]                   iter_count
);

  localparam int DEV_W     = ADDR_WIDTH - SLAVE_MEM_ADDR_WIDTH;
  localparam int BUSY_WAIT = START_PULSE + 4;
  localparam int MAX_A     = (BUSY_WAIT > GAP_CYCLES) ? BUSY_WAIT : GAP_CYCLES;
  localparam int MAX_CNT   = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  // One counter per channel measures pulse, gap, ready-wait and watchdog time.
  localparam int CW        = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(START_PULSE - 1);
  localparam logic [CW-1:0] BUSY_LAST  = CW'(BUSY_WAIT - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [7:0]    K_LAST     = 8'(ITER - 1);
`ifdef BUS_TRAFFIC_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_RDY, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE, S_GAP, S_FIN
  } state_e;

  typedef enum logic [1:0] {ST_W0, ST_W1, ST_RD} step_e;

  logic              go_q, busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [7:0]        err_q, err_d, iter_q, iter_d, err_sat;
  logic [8:0]        err_sum, err_tot;
  logic              start_run, all_fin, iter_inc;
  logic [NUM_CH-1:0] fin_vec, err_vec;

  assign start_run = go & ~go_q & ~busy_q;
  assign all_fin   = busy_q & (&fin_vec);

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      state_e                          state_q, state_d;
      step_e                           step_q, step_d;
      logic [7:0]                      k_q, k_d;
      logic [CW-1:0]                   cnt_q, cnt_d;
      logic                            got_q, got_d;
      logic [DATA_WIDTH-1:0]           rd_q, rd_d;
      logic                            err, adv, rd_done, active, in_req;
      logic [31:0]                     k2;
      logic [DATA_WIDTH-1:0]           d0, rdata_c;
      logic [DEV_W-1:0]                dev;
      logic [SLAVE_MEM_ADDR_WIDTH-1:0] off;

      assign rdata_c = ch_rdata[c*DATA_WIDTH +: DATA_WIDTH];
      assign k2      = {23'd0, k_q, 1'b0};
      assign d0      = DATA_WIDTH'(32'(32 * c) + k2);
      assign dev     = DEV_W'(c + 1);
      assign off     = SLAVE_MEM_ADDR_WIDTH'(k2 + {31'd0, step_q == ST_W1});
      assign active  = (state_q != S_IDLE) && (state_q != S_FIN);
      assign in_req  = (state_q == S_ISSUE) || (state_q == S_WAIT_BUSY) || (state_q == S_WAIT_DONE);

      // Channel sequencing: request handshake, step/iteration advance and read check.
      always_comb begin
        state_d = state_q;
        step_d  = step_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        got_d   = got_q;
        rd_d    = rd_q;
        err     = 1'b0;
        adv     = 1'b0;
        rd_done = 1'b0;

        // Only the first read response of a read step is kept.
        if (in_req && step_q == ST_RD && ch_rvalid[c] && !got_q) begin
          got_d = 1'b1;
          rd_d  = rdata_c;
        end

        case (state_q)
          S_IDLE: begin
            if (start_run) begin
              state_d = S_WAIT_RDY;
              step_d  = ST_W0;
              k_d     = 8'd0;
              cnt_d   = '0;
              got_d   = 1'b0;
            end
          end
          S_WAIT_RDY: begin
            got_d = 1'b0;
            if (ch_ready[c]) begin
              state_d = S_ISSUE;
              cnt_d   = '0;
            end
          end
          S_ISSUE: begin
            if (cnt_q == PULSE_LAST) begin
              state_d = S_WAIT_BUSY;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          S_WAIT_BUSY: begin
            // An adapter that never drops ready is treated as having finished instantly.
            if (!ch_ready[c] || cnt_q == BUSY_LAST) begin
              state_d = S_WAIT_DONE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
          S_WAIT_DONE: begin
            if (ch_ready[c]) begin
              // A response arriving in the exit cycle still counts.
              if (step_q == ST_RD) begin
                err = got_q ? (rd_q != d0) : !(ch_rvalid[c] && rdata_c == d0);
              end
              cnt_d = '0;
              if (GAP_CYCLES == 0) adv = 1'b1;
              else state_d = S_GAP;
            end
          end
          S_GAP: begin
            if (cnt_q == GAP_LAST) adv = 1'b1;
            else cnt_d = cnt_q + CNT_ONE;
          end
          S_FIN: begin
            if (all_fin) state_d = S_IDLE;
          end
          default: state_d = S_IDLE;
        endcase

        if (adv) begin
          state_d = S_WAIT_RDY;
          cnt_d   = '0;
          case (step_q)
            ST_W0:   step_d = ST_W1;
            ST_W1:   step_d = ST_RD;
            default: begin
              step_d  = ST_W0;
              rd_done = 1'b1;
              if (k_q == K_LAST) state_d = S_FIN;
            end
          endcase
        end

        if (rd_done) k_d = k_q + 8'd1;

`ifdef BUS_TRAFFIC_SEQ_TIMEOUT_EN
        // Watchdog: the shared counter restarts on every state change.
        if ((state_q == S_WAIT_RDY || state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE)
            && state_d == state_q) begin
          if (cnt_q == TO_LAST) begin
            state_d = S_FIN;
            err     = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
`endif
      end

      // Channel state registers.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q <= S_IDLE;
          step_q  <= ST_W0;
          k_q     <= 8'd0;
          cnt_q   <= '0;
          got_q   <= 1'b0;
          rd_q    <= '0;
        end else begin
          state_q <= state_d;
          step_q  <= step_d;
          k_q     <= k_d;
          cnt_q   <= cnt_d;
          got_q   <= got_d;
          rd_q    <= rd_d;
        end
      end

      assign ch_start[c] = (state_q == S_ISSUE);
      assign ch_mode[c]  = active && (step_q != ST_RD);
      assign ch_addr[c*ADDR_WIDTH +: ADDR_WIDTH] = active ? {dev, off} : '0;
      assign ch_wdata[c*DATA_WIDTH +: DATA_WIDTH] =
        (active && step_q == ST_W0) ? d0 :
        (active && step_q == ST_W1) ? d0 + DATA_WIDTH'(1) : '0;
      assign fin_vec[c] = (state_q == S_FIN);
      assign err_vec[c] = err;

      if (c == 0) begin : g_iter
        assign iter_inc = rd_done;
      end
    end
  endgenerate

  // Sum this cycle's channel errors into the saturating total.
  always_comb begin
    err_sum = 9'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      err_sum = err_sum + {8'd0, err_vec[i]};
    end
    err_tot = {1'b0, err_q} + err_sum;
    err_sat = err_tot[8] ? 8'hFF : err_tot[7:0];
  end

  // Run control: start on go rising edge, finish when every channel is in FIN.
  always_comb begin
    busy_d = busy_q;
    done_d = done_q;
    pass_d = pass_q;
    err_d  = err_sat;
    iter_d = iter_q + {7'd0, iter_inc};
    if (start_run) begin
      busy_d = 1'b1;
      done_d = 1'b0;
      pass_d = 1'b0;
      err_d  = 8'd0;
      iter_d = 8'd0;
    end else if (all_fin) begin
      busy_d = 1'b0;
      done_d = 1'b1;
      pass_d = (err_q == 8'd0);
    end
  end

  // Run status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= 8'd0;
      iter_q <= 8'd0;
    end else begin
      go_q   <= go;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      err_q  <= err_d;
      iter_q <= iter_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign iter_count = iter_q;

endmodule
